// File: rtl/add_mantissa_process_if.sv
// ---------------------------------------------------------------------------
// add_mantissa_process_if
// Bundles the aligned-operand input word and the adder result word.
//   stall                 : 1 = hold every pipeline register
//   valid/idle/cout/zout  : aligned operands from the align stage
//   sout/Opcode/z_post/InsTag (_Allign) : sideband, carried through unchanged
//   valid/idle/sign/exp/sum (_Add)      : registered adder result
//   sout/Opcode/z_post/InsTag (_Add)    : delayed sideband
// master = producer / result consumer, slave = the adder stage.
// ---------------------------------------------------------------------------
interface add_mantissa_process_if;
    logic        stall;
    logic        valid_Allign;
    logic        idle_Allign;
    logic [35:0] cout_Allign;
    logic [35:0] zout_Allign;
    logic [31:0] sout_Allign;
    logic [3:0]  Opcode_Allign;
    logic [31:0] z_postAllign;
    logic [7:0]  InsTagAllign;

    logic        valid_Add;
    logic        idle_Add;
    logic        sign_Add;
    logic [7:0]  exp_Add;
    logic [27:0] sum_Add;
    logic [31:0] sout_Add;
    logic [3:0]  Opcode_Add;
    logic [31:0] z_postAdd;
    logic [7:0]  InsTagAdd;

    modport master (
        output stall, valid_Allign, idle_Allign, cout_Allign, zout_Allign,
               sout_Allign, Opcode_Allign, z_postAllign, InsTagAllign,
        input  valid_Add, idle_Add, sign_Add, exp_Add, sum_Add,
               sout_Add, Opcode_Add, z_postAdd, InsTagAdd
    );

    modport slave (
        input  stall, valid_Allign, idle_Allign, cout_Allign, zout_Allign,
               sout_Allign, Opcode_Allign, z_postAllign, InsTagAllign,
        output valid_Add, idle_Add, sign_Add, exp_Add, sum_Add,
               sout_Add, Opcode_Add, z_postAdd, InsTagAdd
    );
endinterface

// File: rtl/add_mantissa_process.sv
// ---------------------------------------------------------------------------
// add_mantissa_process
// Signed-magnitude mantissa add/subtract of two pre-aligned operands.
// Two register stages: S1 computes the result, S2 drives the outputs, so
// every output is a flop and latency is two non-stalled clocks.
// Ports:
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset, clears both stages
//   bus     : add_mantissa_process_if.slave (operands in, result out)
// Operand packing: [35] sign, [34:27] biased exponent, [26:0] mantissa.
// The result exponent is Z's; C's exponent is redundant after alignment.
// ---------------------------------------------------------------------------
module add_mantissa_process #(
    parameter logic PUT_IDLE = 1'b1
) (
    input  logic                        clock,
    input  logic                        reset_n,
    add_mantissa_process_if.slave       bus
);

    logic        z_sign_s;
    logic        c_sign_s;
    logic [26:0] z_man_s;
    logic [26:0] c_man_s;
    logic [26:0] z_minus_c_s;
    logic [26:0] c_minus_z_s;
    logic [27:0] sum_s;
    logic        sign_s;
    logic        unused_c_exp_s;

    logic        s1_valid_r;
    logic        s1_idle_r;
    logic        s1_sign_r;
    logic [7:0]  s1_exp_r;
    logic [27:0] s1_sum_r;
    logic [31:0] s1_sout_r;
    logic [3:0]  s1_opcode_r;
    logic [31:0] s1_zpost_r;
    logic [7:0]  s1_tag_r;

    logic        s2_valid_r;
    logic        s2_idle_r;
    logic        s2_sign_r;
    logic [7:0]  s2_exp_r;
    logic [27:0] s2_sum_r;
    logic [31:0] s2_sout_r;
    logic [3:0]  s2_opcode_r;
    logic [31:0] s2_zpost_r;
    logic [7:0]  s2_tag_r;

    assign z_sign_s       = bus.zout_Allign[35];
    assign c_sign_s       = bus.cout_Allign[35];
    assign z_man_s        = bus.zout_Allign[26:0];
    assign c_man_s        = bus.cout_Allign[26:0];
    assign z_minus_c_s    = z_man_s - c_man_s;
    assign c_minus_z_s    = c_man_s - z_man_s;
    assign unused_c_exp_s = ^bus.cout_Allign[34:27];

    // Signed-magnitude add/subtract selecting result sign and magnitude.
    always_comb begin
        sum_s  = 28'd0;
        sign_s = 1'b0;
        if (bus.idle_Allign == PUT_IDLE) begin
            sum_s  = {1'b0, z_man_s};
            sign_s = z_sign_s;
        end else if (z_sign_s == c_sign_s) begin
            // Extra top bit keeps the carry out of the 27-bit add.
            sum_s  = {1'b0, z_man_s} + {1'b0, c_man_s};
            sign_s = z_sign_s;
        end else if (z_man_s >= c_man_s) begin
            sum_s  = {1'b0, z_minus_c_s};
            // Exact cancellation yields +0, never -0.
            sign_s = (z_minus_c_s == 27'd0) ? 1'b0 : z_sign_s;
        end else begin
            sum_s  = {1'b0, c_minus_z_s};
            sign_s = c_sign_s;
        end
    end

    // S1: capture computed result and sideband unless stalled.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_r  <= 1'b0;
            s1_idle_r   <= 1'b0;
            s1_sign_r   <= 1'b0;
            s1_exp_r    <= 8'd0;
            s1_sum_r    <= 28'd0;
            s1_sout_r   <= 32'd0;
            s1_opcode_r <= 4'd0;
            s1_zpost_r  <= 32'd0;
            s1_tag_r    <= 8'd0;
        end else if (!bus.stall) begin
            s1_valid_r  <= bus.valid_Allign;
            s1_idle_r   <= bus.idle_Allign;
            s1_sign_r   <= sign_s;
            s1_exp_r    <= bus.zout_Allign[34:27];
            s1_sum_r    <= sum_s;
            s1_sout_r   <= bus.sout_Allign;
            s1_opcode_r <= bus.Opcode_Allign;
            s1_zpost_r  <= bus.z_postAllign;
            s1_tag_r    <= bus.InsTagAllign;
        end else begin
            s1_valid_r  <= s1_valid_r;
            s1_idle_r   <= s1_idle_r;
            s1_sign_r   <= s1_sign_r;
            s1_exp_r    <= s1_exp_r;
            s1_sum_r    <= s1_sum_r;
            s1_sout_r   <= s1_sout_r;
            s1_opcode_r <= s1_opcode_r;
            s1_zpost_r  <= s1_zpost_r;
            s1_tag_r    <= s1_tag_r;
        end
    end

    // S2: output register, advances from S1 unless stalled.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid_r  <= 1'b0;
            s2_idle_r   <= 1'b0;
            s2_sign_r   <= 1'b0;
            s2_exp_r    <= 8'd0;
            s2_sum_r    <= 28'd0;
            s2_sout_r   <= 32'd0;
            s2_opcode_r <= 4'd0;
            s2_zpost_r  <= 32'd0;
            s2_tag_r    <= 8'd0;
        end else if (!bus.stall) begin
            s2_valid_r  <= s1_valid_r;
            s2_idle_r   <= s1_idle_r;
            s2_sign_r   <= s1_sign_r;
            s2_exp_r    <= s1_exp_r;
            s2_sum_r    <= s1_sum_r;
            s2_sout_r   <= s1_sout_r;
            s2_opcode_r <= s1_opcode_r;
            s2_zpost_r  <= s1_zpost_r;
            s2_tag_r    <= s1_tag_r;
        end else begin
            s2_valid_r  <= s2_valid_r;
            s2_idle_r   <= s2_idle_r;
            s2_sign_r   <= s2_sign_r;
            s2_exp_r    <= s2_exp_r;
            s2_sum_r    <= s2_sum_r;
            s2_sout_r   <= s2_sout_r;
            s2_opcode_r <= s2_opcode_r;
            s2_zpost_r  <= s2_zpost_r;
            s2_tag_r    <= s2_tag_r;
        end
    end

    assign bus.valid_Add  = s2_valid_r;
    assign bus.idle_Add   = s2_idle_r;
    assign bus.sign_Add   = s2_sign_r;
    assign bus.exp_Add    = s2_exp_r;
    assign bus.sum_Add    = s2_sum_r;
    assign bus.sout_Add   = s2_sout_r;
    assign bus.Opcode_Add = s2_opcode_r;
    assign bus.z_postAdd  = s2_zpost_r;
    assign bus.InsTagAdd  = s2_tag_r;

endmodule

// File: tb/tb_add_mantissa_process.sv
// ---------------------------------------------------------------------------
// tb_add_mantissa_process
// Scoreboard bench: each accepted word pushes its expected result, and the
// output monitor pops and compares whenever the pipeline advances with
// valid_Add high. Directed tasks add their own inline checks.
// ---------------------------------------------------------------------------
module tb_add_mantissa_process;

    typedef struct {
        logic        idle;
        logic        sign;
        logic [7:0]  exp;
        logic [27:0] sum;
        logic [31:0] sout;
        logic [3:0]  op;
        logic [31:0] zpost;
        logic [7:0]  tag;
    } exp_t;

    logic clock;
    logic reset_n;
    logic adv_r;
    int   total;
    int   bad;
    exp_t sb_q[$];
    exp_t last_e;

    add_mantissa_process_if bus();

    add_mantissa_process #(.PUT_IDLE(1'b1)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Remembers whether the last rising edge moved the pipeline.
    always @(posedge clock) adv_r <= reset_n && !bus.stall;

    // Signed-integer reference: sign/magnitude from a true signed sum.
    function automatic exp_t model(input logic idle, input logic [35:0] z,
                                   input logic [35:0] c);
        exp_t e;
        logic signed [29:0] zv, cv, r, mag;
        zv = z[35] ? -$signed({3'b000, z[26:0]}) : $signed({3'b000, z[26:0]});
        cv = c[35] ? -$signed({3'b000, c[26:0]}) : $signed({3'b000, c[26:0]});
        r  = zv + cv;
        mag = (r < 0) ? -r : r;
        e.idle = idle;
        e.exp  = z[34:27];
        if (idle) begin
            e.sum  = {1'b0, z[26:0]};
            e.sign = z[35];
        end else if (z[35] == c[35]) begin
            e.sum  = mag[27:0];
            e.sign = z[35];
        end else begin
            e.sum  = mag[27:0];
            e.sign = (r < 0);
        end
        e.sout = 32'd0; e.op = 4'd0; e.zpost = 32'd0; e.tag = 8'd0;
        return e;
    endfunction

    // Output monitor: compares every newly advanced valid word.
    always @(negedge clock) begin
        exp_t e;
        if (reset_n === 1'b1 && adv_r === 1'b1 && bus.valid_Add === 1'b1) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_out: got tag=%0h, expected no output", bus.InsTagAdd);
            end else begin
                e = sb_q.pop_front();
                last_e = e;
                if ({bus.idle_Add, bus.sign_Add, bus.exp_Add, bus.sum_Add, bus.sout_Add,
                     bus.Opcode_Add, bus.z_postAdd, bus.InsTagAdd} !==
                    {e.idle, e.sign, e.exp, e.sum, e.sout, e.op, e.zpost, e.tag}) begin
                    bad++;
                    $display("FAIL scoreboard: got tag=%0h idle=%0b sign=%0b exp=%0d sum=%0h sout=%0h op=%0h zp=%0h, expected tag=%0h idle=%0b sign=%0b exp=%0d sum=%0h sout=%0h op=%0h zp=%0h",
                             bus.InsTagAdd, bus.idle_Add, bus.sign_Add, bus.exp_Add, bus.sum_Add,
                             bus.sout_Add, bus.Opcode_Add, bus.z_postAdd,
                             e.tag, e.idle, e.sign, e.exp, e.sum, e.sout, e.op, e.zpost);
                end
            end
        end
    end

    task automatic set_word(input logic idle, input logic [35:0] z,
                            input logic [35:0] c, input logic [7:0] tag);
        exp_t e;
        e = model(idle, z, c);
        e.sout = $urandom; e.op = 4'($urandom); e.zpost = $urandom; e.tag = tag;
        bus.valid_Allign  = 1'b1;
        bus.idle_Allign   = idle;
        bus.zout_Allign   = z;
        bus.cout_Allign   = c;
        bus.sout_Allign   = e.sout;
        bus.Opcode_Allign = e.op;
        bus.z_postAllign  = e.zpost;
        bus.InsTagAllign  = tag;
        sb_q.push_back(e);
    endtask

    task automatic put(input logic idle, input logic [35:0] z,
                       input logic [35:0] c, input logic [7:0] tag);
        set_word(idle, z, c, tag);
        @(negedge clock);
    endtask

    task automatic quiet(input int n);
        bus.valid_Allign = 1'b0;
        bus.cout_Allign  = 36'($urandom);
        bus.zout_Allign  = 36'($urandom);
        repeat (n) @(negedge clock);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        bus.stall = 1'b0; bus.valid_Allign = 1'b0; bus.idle_Allign = 1'b0;
        bus.cout_Allign = 36'd0; bus.zout_Allign = 36'd0; bus.sout_Allign = 32'd0;
        bus.Opcode_Allign = 4'd0; bus.z_postAllign = 32'd0; bus.InsTagAllign = 8'd0;
        repeat (2) @(negedge clock);
        total++;
        if ({bus.valid_Add, bus.idle_Add, bus.sign_Add, bus.exp_Add, bus.sum_Add, bus.sout_Add,
             bus.Opcode_Add, bus.z_postAdd, bus.InsTagAdd} !== 115'd0) begin
            bad++;
            $display("FAIL reset_outputs: got valid=%0b sum=%0h tag=%0h, expected all zero",
                     bus.valid_Add, bus.sum_Add, bus.InsTagAdd);
        end
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_same_sign;
        put(1'b0, {1'b0, 8'd130, 27'h4000000}, {1'b0, 8'd130, 27'h4000000}, 8'h10);
        bus.valid_Allign = 1'b0;
        total++;
        if (bus.valid_Add !== 1'b0) begin
            bad++; $display("FAIL latency_early: got valid_Add=%0b, expected 0", bus.valid_Add);
        end
        quiet(1);
        total++;
        if ({bus.valid_Add, bus.sum_Add, bus.sign_Add, bus.exp_Add} !== {1'b1, 28'h8000000, 1'b0, 8'd130}) begin
            bad++;
            $display("FAIL same_sign: got valid=%0b sum=%0h sign=%0b exp=%0d, expected 1 8000000 0 130",
                     bus.valid_Add, bus.sum_Add, bus.sign_Add, bus.exp_Add);
        end
        quiet(1);
    endtask

    task automatic test_diff_sign;
        put(1'b0, {1'b0, 8'd100, 27'h0000010}, {1'b1, 8'd7, 27'h0000030}, 8'h11);
        quiet(1);
        total++;
        if ({bus.sum_Add, bus.sign_Add, bus.exp_Add} !== {28'h0000020, 1'b1, 8'd100}) begin
            bad++;
            $display("FAIL diff_sign_c_larger: got sum=%0h sign=%0b exp=%0d, expected 20 1 100",
                     bus.sum_Add, bus.sign_Add, bus.exp_Add);
        end
        put(1'b0, {1'b1, 8'd90, 27'h0000050}, {1'b0, 8'd90, 27'h0000008}, 8'h12);
        quiet(1);
        total++;
        if ({bus.sum_Add, bus.sign_Add} !== {28'h0000048, 1'b1}) begin
            bad++;
            $display("FAIL diff_sign_z_larger: got sum=%0h sign=%0b, expected 48 1",
                     bus.sum_Add, bus.sign_Add);
        end
        quiet(1);
    endtask

    task automatic test_cancel;
        put(1'b0, {1'b1, 8'd50, 27'h1234567}, {1'b0, 8'd50, 27'h1234567}, 8'h13);
        quiet(1);
        total++;
        if ({bus.valid_Add, bus.sum_Add, bus.sign_Add} !== {1'b1, 28'h0, 1'b0}) begin
            bad++;
            $display("FAIL cancel: got valid=%0b sum=%0h sign=%0b, expected 1 0 0",
                     bus.valid_Add, bus.sum_Add, bus.sign_Add);
        end
        quiet(1);
    endtask

    task automatic test_idle;
        put(1'b1, {1'b1, 8'd201, 27'h7FFFFFF}, {1'b1, 8'd3, 27'h5A5A5A5}, 8'h14);
        quiet(1);
        total++;
        if ({bus.sum_Add, bus.sign_Add, bus.exp_Add, bus.idle_Add} !== {28'h7FFFFFF, 1'b1, 8'd201, 1'b1}) begin
            bad++;
            $display("FAIL idle_bypass: got sum=%0h sign=%0b exp=%0d idle=%0b, expected 7ffffff 1 201 1",
                     bus.sum_Add, bus.sign_Add, bus.exp_Add, bus.idle_Add);
        end
        quiet(1);
    endtask

    task automatic test_random;
        logic [35:0] z, c;
        for (int i = 0; i < 24; i++) begin
            z = {1'($urandom), 8'($urandom), 27'($urandom)};
            c = {1'($urandom), 8'($urandom), 27'($urandom)};
            if (i % 4 == 0) c[26:0] = z[26:0];
            put(1'($urandom_range(0, 5) == 0), z, c, 8'(8'h40 + i));
        end
        quiet(3);
    endtask

    task automatic test_back_to_back_stall;
        put(1'b0, {1'b0, 8'd1, 27'h0000001}, {1'b0, 8'd1, 27'h0000002}, 8'd1);
        put(1'b0, {1'b1, 8'd2, 27'h0000100}, {1'b0, 8'd2, 27'h0000001}, 8'd2);
        set_word(1'b0, {1'b0, 8'd3, 27'h3000000}, {1'b0, 8'd3, 27'h3000000}, 8'd3);
        bus.stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            total++;
            if ({bus.valid_Add, bus.InsTagAdd, bus.sum_Add} !== {1'b1, last_e.tag, last_e.sum}) begin
                bad++;
                $display("FAIL stall_hold[%0d]: got valid=%0b tag=%0d sum=%0h, expected 1 %0d %0h",
                         k, bus.valid_Add, bus.InsTagAdd, bus.sum_Add, last_e.tag, last_e.sum);
            end
        end
        bus.stall = 1'b0;
        @(negedge clock);
        quiet(3);
    endtask

    task automatic test_reset_midflight;
        put(1'b0, {1'b0, 8'd9, 27'h0000111}, {1'b0, 8'd9, 27'h0000222}, 8'hE1);
        set_word(1'b0, {1'b0, 8'd9, 27'h0000333}, {1'b1, 8'd9, 27'h0000001}, 8'hE2);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if ({bus.valid_Add, bus.idle_Add, bus.sign_Add, bus.exp_Add, bus.sum_Add, bus.sout_Add,
             bus.Opcode_Add, bus.z_postAdd, bus.InsTagAdd} !== 115'd0) begin
            bad++;
            $display("FAIL reset_midflight: got valid=%0b tag=%0h sum=%0h, expected all zero",
                     bus.valid_Add, bus.InsTagAdd, bus.sum_Add);
        end
        sb_q.delete();
        bus.valid_Allign = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            total++;
            if (bus.valid_Add !== 1'b0) begin
                bad++;
                $display("FAIL stale_after_reset[%0d]: got valid=%0b tag=%0h, expected valid 0",
                         k, bus.valid_Add, bus.InsTagAdd);
            end
        end
        put(1'b0, {1'b0, 8'd77, 27'h0000005}, {1'b0, 8'd77, 27'h0000006}, 8'hA5);
        quiet(3);
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        adv_r  = 1'b0;
        test_reset();
        test_same_sign();
        test_diff_sign();
        test_cancel();
        test_idle();
        test_random();
        test_back_to_back_stall();
        test_reset_midflight();
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d words still pending, expected 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
